// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
package mul_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int N_DEFAULT = 10;
endpackage

// File: rtl/mul_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: first valid index after i_ptr, wrapping.
module rr_arbiter #(
  parameter int  NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx,
  output logic            o_any_grant
);
  int           w_pos;
  logic [IDW-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_pos       = 0;
    w_idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      w_idx = IDW'(w_pos);
      if (!o_any_grant && i_valid[w_idx]) begin
        o_any_grant    = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end
endmodule

// File: rtl/mul_rr_scheduler_multiplier.sv
// Combinational radix-4 Booth multiplier; o_carry is the carry out of the
// final (most significant digit) partial-product addition.
module multiplier #(
  parameter int N = 10
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_product,
  output logic           o_carry
);
  localparam int W = 2 * N;

  logic [W-1:0] w_a1;
  logic [W-1:0] w_a2;
  logic [N:0]   w_b_ext;
  logic [2:0]   w_trip;
  logic [W-1:0] w_pp;
  logic [W:0]   w_sum;
  logic [W-1:0] w_acc;

  assign w_a1    = {{N{i_a[N-1]}}, i_a};
  assign w_a2    = w_a1 << 1;
  assign w_b_ext = {i_b, 1'b0};

  always_comb begin
    w_trip  = '0;
    w_pp    = '0;
    w_sum   = '0;
    w_acc   = '0;
    o_carry = 1'b0;
    for (int i = 0; i < N / 2; i++) begin
      w_trip = w_b_ext[2*i +: 3];
      case (w_trip)
        3'b001, 3'b010: w_pp = w_a1;
        3'b011:         w_pp = w_a2;
        3'b100:         w_pp = -w_a2;
        3'b101, 3'b110: w_pp = -w_a1;
        default:        w_pp = '0;
      endcase
      w_pp    = w_pp << (2 * i);
      w_sum   = {1'b0, w_acc} + {1'b0, w_pp};
      w_acc   = w_sum[W-1:0];
      o_carry = w_sum[W];
    end
    o_product = w_acc;
  end
endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one Booth multiplier between NREQ requesters, round-robin, with a
// registered operand stage and a one-entry valid/ready response buffer.
module mul_rr_scheduler
  import mul_sched_pkg::*;
#(
  parameter int  N    = N_DEFAULT,
  parameter int  NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0][N-1:0]  req_a,
  input  logic [NREQ-1:0][N-1:0]  req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*N-1:0]          rsp_result,
  output logic                    rsp_carry,
  output logic [IDW-1:0]          rsp_id,
  output logic                    busy
);
  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_id;
  logic [N-1:0]   r_op_a;
  logic [N-1:0]   r_op_b;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grant_idx;
  logic            w_any_grant;
  logic            w_can_accept;
  logic            w_accept;
  logic [2*N-1:0]  w_product;
  logic            w_carry;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_valid     (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  multiplier #(.N(N)) u_mul (
    .i_a       (r_op_a),
    .i_b       (r_op_b),
    .o_product (w_product),
    .o_carry   (w_carry)
  );

  // Valid/ready: a transfer happens on an edge where both are high; the
  // producer holds valid and data stable until then, and the response
  // buffer likewise holds rsp_* stable until rsp_ready.
  assign w_can_accept = !rst && ((r_state == IDLE) || (r_state == HOLD && rsp_ready));
  assign req_ready    = w_can_accept ? w_grant : '0;
  assign w_accept     = w_can_accept && w_any_grant;
  assign busy         = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= IDW'(NREQ - 1);
      r_id       <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_a   <= req_a[w_grant_idx];
            r_op_b   <= req_b[w_grant_idx];
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_grant_idx;
            r_state  <= MUL;
          end
        end
        MUL: begin
          rsp_result <= w_product;
          rsp_carry  <= w_carry;
          rsp_id     <= r_id;
          rsp_valid  <= 1'b1;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (w_accept) begin
              r_op_a   <= req_a[w_grant_idx];
              r_op_b   <= req_b[w_grant_idx];
              r_id     <= w_grant_idx;
              r_rr_ptr <= w_grant_idx;
              r_state  <= MUL;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed bench for mul_rr_scheduler (N=10, NREQ=2) with hand-computed products.
module tb_mul_rr_scheduler;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][9:0]  req_a;
  logic [1:0][9:0]  req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [19:0]      rsp_result;
  logic             rsp_carry;
  logic [0:0]       rsp_id;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [9:0]  fa[6];
  logic [9:0]  fb[6];
  logic [19:0] fp[6];

  always #5 clk = ~clk;

  mul_rr_scheduler #(.N(10), .NREQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    fa[0] = 10'd2;   fb[0] = 10'd3;   fp[0] = 20'd6;
    fa[1] = 10'd4;   fb[1] = 10'd5;   fp[1] = 20'd20;
    fa[2] = 10'h3FE; fb[2] = 10'd6;   fp[2] = 20'hFFFF4;
    fa[3] = 10'd7;   fb[3] = 10'd7;   fp[3] = 20'h00031;
    fa[4] = 10'd100; fb[4] = 10'h3FF; fp[4] = 20'hFFF9C;
    fa[5] = 10'd511; fb[5] = 10'd511; fp[5] = 20'h3FC01;

    // reset state, with a request already presented
    rst = 1'b1; rsp_ready = 1'b0; req_valid = 2'b01;
    req_a = '0; req_b = '0;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_result", 32'(rsp_result), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // single request on requester 0: 3*5
    req_a[0] = 10'd3; req_b[0] = 10'd5; req_valid = 2'b01;
    #1 check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    check("t1_mul_busy", 32'(busy), 32'h1);
    check("t1_mul_valid", 32'(rsp_valid), 32'h0);
    tick();
    check("t1_valid", 32'(rsp_valid), 32'h1);
    check("t1_result", 32'(rsp_result), 32'h0000F);
    check("t1_carry", 32'(rsp_carry), 32'h0);
    check("t1_id", 32'(rsp_id), 32'h0);
    rsp_ready = 1'b1;
    tick();
    check("t1_idle_valid", 32'(rsp_valid), 32'h0);
    check("t1_idle_busy", 32'(busy), 32'h0);

    // signed: -3*7 on requester 1
    rsp_ready = 1'b0;
    req_a[1] = 10'h3FD; req_b[1] = 10'd7; req_valid = 2'b10;
    #1 check("t2_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    check("t2_result", 32'(rsp_result), 32'hFFFEB);
    check("t2_carry", 32'(rsp_carry), 32'h0);
    check("t2_id", 32'(rsp_id), 32'h1);
    rsp_ready = 1'b1;
    tick();

    // -512 * -512 on requester 0
    rsp_ready = 1'b0;
    req_a[0] = 10'h200; req_b[0] = 10'h200; req_valid = 2'b01;
    #1 check("t3_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    tick();
    check("t3_result", 32'(rsp_result), 32'h40000);
    check("t3_carry", 32'(rsp_carry), 32'h0);
    check("t3_id", 32'(rsp_id), 32'h0);
    rsp_ready = 1'b1;
    tick();

    // -1 * -255 on requester 1: last Booth add carries out
    rsp_ready = 1'b0;
    req_a[1] = 10'h3FF; req_b[1] = 10'h301; req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    check("t4_result", 32'(rsp_result), 32'h000FF);
    check("t4_carry", 32'(rsp_carry), 32'h1);
    check("t4_id", 32'(rsp_id), 32'h1);
    rsp_ready = 1'b1;
    tick();
    check("t4_idle_busy", 32'(busy), 32'h0);

    // fairness, back-to-back with rsp_ready held high
    req_a[0] = fa[0]; req_b[0] = fb[0];
    req_a[1] = fa[1]; req_b[1] = fb[1];
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1 check("fair_ready", 32'(req_ready), 32'(1 << (i % 2)));
      tick();
      if (i + 2 < 6) begin
        req_a[i % 2] = fa[i + 2];
        req_b[i % 2] = fb[i + 2];
      end else begin
        req_valid[i % 2] = 1'b0;
      end
      check("fair_mul_valid", 32'(rsp_valid), 32'h0);
      check("fair_mul_ready", 32'(req_ready), 32'h0);
      tick();
      check("fair_valid", 32'(rsp_valid), 32'h1);
      check("fair_result", 32'(rsp_result), 32'(fp[i]));
      check("fair_id", 32'(rsp_id), 32'(i % 2));
    end
    tick();
    check("fair_idle", 32'(busy), 32'h0);

    // backpressure: 6*7 held while requester 1 waits with 8*9
    rsp_ready = 1'b0;
    req_a[0] = 10'd6; req_b[0] = 10'd7; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    req_a[1] = 10'd8; req_b[1] = 10'd9; req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_result", 32'(rsp_result), 32'h0002A);
      check("bp_id", 32'(rsp_id), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("bp_b2b_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    check("bp_b2b_valid", 32'(rsp_valid), 32'h0);
    check("bp_b2b_busy", 32'(busy), 32'h1);
    tick();
    check("bp2_result", 32'(rsp_result), 32'h00048);
    check("bp2_id", 32'(rsp_id), 32'h1);
    tick();

    // reset during MUL after a grant to requester 0
    req_a[0] = 10'd3; req_b[0] = 10'd3; req_valid = 2'b01;
    tick();
    check("rm_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("rm_busy", 32'(busy), 32'h0);
    check("rm_valid", 32'(rsp_valid), 32'h0);
    check("rm_ready", 32'(req_ready), 32'h0);
    check("rm_result", 32'(rsp_result), 32'h0);
    tick();
    rst = 1'b0; req_valid = 2'b00;
    tick(); tick();
    check("rm_no_stale", 32'(rsp_valid), 32'h0);
    check("rm_idle", 32'(busy), 32'h0);
    req_a[1] = 10'd5; req_b[1] = 10'd5; req_valid = 2'b11;
    #1 check("rm_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    tick();
    check("rm_result2", 32'(rsp_result), 32'h00009);
    check("rm_id2", 32'(rsp_id), 32'h0);
    tick();
    check("rm_end_idle", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
